// File: rtl/any1_sel_split_if.sv
// Request/beat bundle between the memory-op issue logic and the bus
// interface unit. Signal suffixes are from the splitter's point of view.
interface any1_sel_split_if #(
    parameter int BUS_BYTES = 8,
    parameter int AW        = 32
);
    localparam int OW = $clog2(BUS_BYTES);

    logic                 req_vld_i;
    logic                 req_rdy_o;
    logic [AW-1:0]        req_adr_i;
    logic [2:0]           req_sz_i;
    logic                 beat_vld_o;
    logic                 beat_rdy_i;
    logic [AW-1:0]        beat_adr_o;
    logic [BUS_BYTES-1:0] beat_sel_o;
    logic [OW-1:0]        beat_ofs_o;
    logic                 beat_first_o;
    logic                 beat_last_o;
    logic                 err_o;

    // Splitter side.
    modport slave (
        input  req_vld_i, req_adr_i, req_sz_i, beat_rdy_i,
        output req_rdy_o, beat_vld_o, beat_adr_o, beat_sel_o, beat_ofs_o,
               beat_first_o, beat_last_o, err_o
    );

    // Issue logic / bus unit side.
    modport master (
        output req_vld_i, req_adr_i, req_sz_i, beat_rdy_i,
        input  req_rdy_o, beat_vld_o, beat_adr_o, beat_sel_o, beat_ofs_o,
               beat_first_o, beat_last_o, err_o
    );
endinterface

// File: rtl/any1_sel_split.sv
// Byte-lane select generator and unaligned-access splitter for the ANY-1
// memory unit. One request (address, size code) becomes one or two bus beats,
// each with a bus-word-aligned address and a byte-lane select. A request whose
// byte span crosses a bus word is split into a low beat and a high beat.
module any1_sel_split #(
    parameter int BUS_BYTES = 8,
    parameter int AW        = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    any1_sel_split_if.slave bus
);
    localparam int OW = $clog2(BUS_BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-OW){1'b1}}, {OW{1'b0}}};
    localparam logic [AW-1:0] BUS_STRIDE = AW'(BUS_BYTES);
    localparam logic [8:0]    BB9        = 9'(BUS_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        adr_q, adr_d;
    logic [BUS_BYTES-1:0] sel_q, sel_d;
    logic [BUS_BYTES-1:0] sel_hi_q, sel_hi_d;   // lanes held back for beat 2
    logic [OW-1:0]        ofs_q, ofs_d;
    logic                 split_q, split_d;
    logic                 err_q, err_d;

    logic [8:0]             n_bytes_s;
    logic                   legal_s;
    logic [2*BUS_BYTES-1:0] len_mask_s;
    logic [2*BUS_BYTES-1:0] lane_mask_s;
    logic                   beat_vld_s;
    logic                   beat_last_s;
    logic                   beat_hs_s;
    logic                   req_rdy_s;
    logic                   req_acc_s;

    // Build the double-width lane mask for the incoming request and judge its size.
    always_comb begin
        n_bytes_s  = 9'd1 << bus.req_sz_i;
        legal_s    = (bus.req_sz_i <= 3'd5) && (n_bytes_s <= BB9);
        len_mask_s = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            len_mask_s[i] = (9'(i) < n_bytes_s);
        end
        lane_mask_s = len_mask_s << bus.req_adr_i[OW-1:0];
    end

    // Beat-side decode from the state register; a new request slips in as the last beat leaves.
    always_comb begin
        beat_vld_s  = (state_q != ST_IDLE);
        beat_last_s = (state_q == ST_BEAT2) || ((state_q == ST_BEAT1) && !split_q);
        beat_hs_s   = beat_vld_s && bus.beat_rdy_i;
        req_rdy_s   = !rst_i && ((state_q == ST_IDLE) || (beat_hs_s && beat_last_s));
        req_acc_s   = bus.req_vld_i && req_rdy_s;
    end

    // Next-state: advance through the beats, then let an accepted request override.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        sel_hi_d = sel_hi_q;
        ofs_d    = ofs_q;
        split_d  = split_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_BEAT1: begin
                if (beat_hs_s) begin
                    if (split_q) begin
                        state_d = ST_BEAT2;
                        adr_d   = adr_q + BUS_STRIDE;   // wraps at the top of the address space
                        sel_d   = sel_hi_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_BEAT1;
                end
            end
            ST_BEAT2: begin
                if (beat_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BEAT2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case ({req_acc_s, legal_s})
            2'b11: begin
                state_d  = ST_BEAT1;
                adr_d    = bus.req_adr_i & ALIGN_MASK;
                sel_d    = lane_mask_s[BUS_BYTES-1:0];
                sel_hi_d = lane_mask_s[2*BUS_BYTES-1:BUS_BYTES];
                ofs_d    = bus.req_adr_i[OW-1:0];
                split_d  = |lane_mask_s[2*BUS_BYTES-1:BUS_BYTES];
            end
            2'b10: begin
                // Oversized request: swallow it and flag the error for one cycle.
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase
    end

    // State and beat registers; reset abandons any request in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            sel_q    <= '0;
            sel_hi_q <= '0;
            ofs_q    <= '0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            sel_hi_q <= sel_hi_d;
            ofs_q    <= ofs_d;
            split_q  <= split_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_rdy_o    = req_rdy_s;
    assign bus.beat_vld_o   = beat_vld_s;
    assign bus.beat_adr_o   = adr_q;
    assign bus.beat_sel_o   = sel_q;
    assign bus.beat_ofs_o   = ofs_q;
    assign bus.beat_first_o = (state_q == ST_BEAT1);
    assign bus.beat_last_o  = beat_last_s;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_any1_sel_split.sv
// Bench for any1_sel_split (BUS_BYTES=8, AW=32): a request-level model turns
// each accepted request into the list of beats it must produce, and a per-cycle
// compare process checks the DUT against it; directed tests pin literal values.
module tb_any1_sel_split;
    typedef struct {
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [2:0]  ofs;
        logic        first;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   err_seen = 0;
    int   acc_cyc  = 0;
    logic chk_en   = 1'b0;
    logic tog_en   = 1'b0;
    logic err_exp  = 1'b0;
    logic acc_c    = 1'b0;
    logic hs_c     = 1'b0;
    logic [31:0] acc_adr_c;
    logic [2:0]  acc_sz_c;

    beat_t exp_q[$];
    beat_t obs[$];
    int    obs_cyc[$];

    any1_sel_split_if #(.BUS_BYTES(8), .AW(32)) bus ();

    any1_sel_split #(.BUS_BYTES(8), .AW(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Model: the beats a request must produce, straight from the lane-mask rule.
    function automatic logic model_push(input logic [31:0] a, input logic [2:0] s);
        int          n;
        int          ofs;
        int          m;
        logic [31:0] base;
        n = 1 << s;
        if (s > 3'd5 || n > 8) return 1'b0;
        ofs  = int'(a % 32'd8);
        m    = ((1 << n) - 1) << ofs;
        base = a - 32'(ofs);
        exp_q.push_back('{adr: base, sel: 8'(m), ofs: 3'(ofs), first: 1'b1, last: ((m >> 8) == 0)});
        if ((m >> 8) != 0)
            exp_q.push_back('{adr: base + 32'd8, sel: 8'(m >> 8), ofs: 3'(ofs), first: 1'b0, last: 1'b1});
        return 1'b1;
    endfunction

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Model update at the clock edge from handshakes captured half a cycle earlier.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            err_exp <= 1'b0;
        end else begin
            if (hs_c && exp_q.size() > 0) exp_q.pop_front();
            if (acc_c) err_exp <= !model_push(acc_adr_c, acc_sz_c);
            else       err_exp <= 1'b0;
        end
    end

    // Compare process: check every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        acc_c     <= bus.req_vld_i & bus.req_rdy_o;
        hs_c      <= bus.beat_vld_o & bus.beat_rdy_i;
        acc_adr_c <= bus.req_adr_i;
        acc_sz_c  <= bus.req_sz_i;
        if (!rst && chk_en) begin
            chk("beat_vld", bus.beat_vld_o, exp_q.size() != 0);
            chk("err", bus.err_o, err_exp);
            chk("req_rdy", bus.req_rdy_o,
                (exp_q.size() == 0) || (exp_q.size() == 1 && bus.beat_rdy_i));
            if (bus.beat_vld_o && exp_q.size() != 0) begin
                chk("beat_adr",   bus.beat_adr_o,   exp_q[0].adr);
                chk("beat_sel",   bus.beat_sel_o,   exp_q[0].sel);
                chk("beat_ofs",   bus.beat_ofs_o,   exp_q[0].ofs);
                chk("beat_first", bus.beat_first_o, exp_q[0].first);
                chk("beat_last",  bus.beat_last_o,  exp_q[0].last);
            end
            if (bus.err_o) err_seen <= err_seen + 1;
            if (bus.beat_vld_o && bus.beat_rdy_i) begin
                obs.push_back('{adr: bus.beat_adr_o, sel: bus.beat_sel_o, ofs: bus.beat_ofs_o,
                                first: bus.beat_first_o, last: bus.beat_last_o});
                obs_cyc.push_back(cyc);
            end
        end
    end

    // Bus back-pressure pattern for the sweep.
    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            bus.beat_rdy_i = (cyc % 3 != 0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [2:0] s);
        logic done;
        done = 1'b0;
        bus.req_vld_i = 1'b1;
        bus.req_adr_i = a;
        bus.req_sz_i  = s;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.req_rdy_o) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!done) chk("issue_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.req_vld_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int k = 0; k < 60 && !idle; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.beat_vld_o) idle = 1'b1;
        end
        if (!idle) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_obs(input int i, input logic [31:0] a, input logic [7:0] s,
                           input logic [2:0] o, input logic [1:0] fl);
        if (obs.size() <= i) begin
            chk("obs_missing", 64'(obs.size()), 64'(i + 1));
        end else begin
            chk("lit_adr", obs[i].adr, a);
            chk("lit_sel", obs[i].sel, s);
            chk("lit_ofs", obs[i].ofs, o);
            chk("lit_first_last", {obs[i].first, obs[i].last}, fl);
        end
    endtask

    initial begin
        int e0;
        bus.req_vld_i  = 1'b0;
        bus.req_adr_i  = 32'd0;
        bus.req_sz_i   = 3'd0;
        bus.beat_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",   bus.beat_vld_o,   1'b0);
        chk("rst_adr",   bus.beat_adr_o,   32'd0);
        chk("rst_sel",   bus.beat_sel_o,   8'd0);
        chk("rst_ofs",   bus.beat_ofs_o,   3'd0);
        chk("rst_first", bus.beat_first_o, 1'b0);
        chk("rst_last",  bus.beat_last_o,  1'b0);
        chk("rst_err",   bus.err_o,        1'b0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", bus.req_rdy_o, 1'b1);
        @(posedge clk);
        #1;

        // Byte, single beat, one cycle after acceptance.
        obs.delete(); obs_cyc.delete();
        issue(32'h0000_1003, 3'd0);
        wait_idle();
        chk("byte_nbeats", 64'(obs.size()), 64'd1);
        chk_obs(0, 32'h0000_1000, 8'h08, 3'd3, 2'b11);
        if (obs_cyc.size() > 0) chk("byte_latency", 64'(obs_cyc[0] - acc_cyc), 64'd1);

        // Tetra straddling a bus word.
        obs.delete(); obs_cyc.delete();
        issue(32'h0000_1006, 3'd2);
        wait_idle();
        chk("tetra_nbeats", 64'(obs.size()), 64'd2);
        chk_obs(0, 32'h0000_1000, 8'hC0, 3'd6, 2'b10);
        chk_obs(1, 32'h0000_1008, 8'h03, 3'd6, 2'b01);

        // Back-to-back octa then wyde with no bubble.
        obs.delete(); obs_cyc.delete();
        issue(32'h0000_2000, 3'd3);
        issue(32'h0000_2010, 3'd1);
        wait_idle();
        chk_obs(0, 32'h0000_2000, 8'hFF, 3'd0, 2'b11);
        chk_obs(1, 32'h0000_2010, 8'h03, 3'd0, 2'b11);
        if (obs_cyc.size() > 1) chk("b2b_gap", 64'(obs_cyc[1] - obs_cyc[0]), 64'd1);

        // Stalled first beat holds, then the split proceeds.
        obs.delete(); obs_cyc.delete();
        bus.beat_rdy_i = 1'b0;
        issue(32'h0000_1006, 3'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_adr",   bus.beat_adr_o,   32'h0000_1000);
            chk("stall_sel",   bus.beat_sel_o,   8'hC0);
            chk("stall_first", bus.beat_first_o, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.beat_rdy_i = 1'b1;
        wait_idle();
        chk_obs(0, 32'h0000_1000, 8'hC0, 3'd6, 2'b10);
        chk_obs(1, 32'h0000_1008, 8'h03, 3'd6, 2'b01);

        // Octa at the top of the address space wraps the second beat to zero.
        obs.delete(); obs_cyc.delete();
        issue(32'hFFFF_FFFC, 3'd3);
        wait_idle();
        chk_obs(0, 32'hFFFF_FFF8, 8'hF0, 3'd4, 2'b10);
        chk_obs(1, 32'h0000_0000, 8'h0F, 3'd4, 2'b01);

        // Illegal sizes: one error pulse each, no beats.
        obs.delete(); obs_cyc.delete();
        e0 = err_seen;
        issue(32'h0000_1000, 3'd4);
        wait_idle();
        chk("err_sz4_count", 64'(err_seen - e0), 64'd1);
        issue(32'h0000_1000, 3'd7);
        issue(32'h0000_1008, 3'd5);
        wait_idle();
        chk("err_total", 64'(err_seen - e0), 64'd3);
        chk("err_nbeats", 64'(obs.size()), 64'd0);

        // Reset during the second beat abandons it.
        issue(32'h0000_1006, 3'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_vld",  bus.beat_vld_o,  1'b1);
        chk("mid_last", bus.beat_last_o, 1'b1);
        chk("mid_adr",  bus.beat_adr_o,  32'h0000_1008);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_vld",  bus.beat_vld_o,  1'b0);
        chk("rst2_sel",  bus.beat_sel_o,  8'd0);
        chk("rst2_adr",  bus.beat_adr_o,  32'd0);
        chk("rst2_last", bus.beat_last_o, 1'b0);
        @(posedge clk);
        #1;

        // Sweep every offset and legal size under back-pressure.
        tog_en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int o = 0; o < 8; o++) begin
                issue(32'h0000_3000 + 32'(s * 64) + 32'(o), 3'(s));
            end
        end
        wait_idle();
        tog_en = 1'b0;
        #2;
        bus.beat_rdy_i = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule
